seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/bcd_to_seg7.sv | 34 +++
 rtl/seg7_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ============================================================================
// Package     : seg7_pkg
// Description : Shared seven-segment types, digit count and segment patterns.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam int NUM_DIGITS = 4;

    // Bit order {a,b,c,d,e,f,g}, segment a at bit 6, active-high.
    localparam seg7_t SEG_0     = 7'h7E;
    localparam seg7_t SEG_1     = 7'h30;
    localparam seg7_t SEG_2     = 7'h6D;
    localparam seg7_t SEG_3     = 7'h79;
    localparam seg7_t SEG_4     = 7'h33;
    localparam seg7_t SEG_5     = 7'h5B;
    localparam seg7_t SEG_6     = 7'h5F;
    localparam seg7_t SEG_7     = 7'h70;
    localparam seg7_t SEG_8     = 7'h7F;
    localparam seg7_t SEG_9     = 7'h7B;
    localparam seg7_t SEG_BLANK = 7'h00;

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg7.sv
// ============================================================================
// Module      : bcd_to_seg7
// Description : Combinational BCD nibble to seven-segment decoder; 10..15 blank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output seg7_t      seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Four-digit multiplexed seven-segment scanner with a
//               double-buffered display value committed at frame boundaries.
//               Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [6:0]  seg,
    output logic [3:0]  dig,
    output logic        frame_done
);

    localparam int               CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      disp_q, disp_d;
    logic [15:0]      pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic             load_ready_q, load_ready_d;
    seg7_t            seg_q, seg_d;
    logic [3:0]       dig_q, dig_d;
    logic             frame_done_q, frame_done_d;

    logic             tick;
    logic             wrap;
    logic             load_acc;
    logic [3:0]       nibble;
    seg7_t            dec_seg;
    logic             blank;

    assign nibble = disp_q[{idx_q, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .bcd (nibble),
        .seg (dec_seg)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [1:0] top_idx;

    // Digit 0 is the floor, so an all-zero display still shows a single 0.
    always_comb begin
        top_idx = 2'd0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (disp_q[i*4 +: 4] != 4'd0) begin
                top_idx = 2'(i);
            end
        end
        blank = (idx_q > top_idx);
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        tick     = enable && (cnt_q == CNT_MAX);
        wrap     = tick && (idx_q == 2'd3);
        load_acc = load_valid && load_ready_q;

        cnt_d = '0;
        if (enable && !tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        idx_d = tick ? (idx_q + 2'd1) : idx_q;

        // Commit and accept never coincide: accept needs an empty buffer,
        // commit needs a full one.
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (wrap && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (load_acc) begin
            pend_d      = load_data;
            pend_full_d = 1'b1;
        end
        load_ready_d = ~pend_full_d;

        dig_d = 4'b0000;
        seg_d = SEG_BLANK;
        if (enable) begin
            dig_d = 4'b0001 << idx_q;
            seg_d = blank ? SEG_BLANK : dec_seg;
        end

        frame_done_d = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            disp_q       <= 16'h0000;
            pend_q       <= 16'h0000;
            pend_full_q  <= 1'b0;
            load_ready_q <= 1'b1;
            seg_q        <= SEG_BLANK;
            dig_q        <= 4'b0000;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            load_ready_q <= load_ready_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign seg        = seg_q;
    assign dig        = dig_q;
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Scoreboard bench for seg7_scan_ctrl with SCAN_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [6:0]  seg;
    logic [3:0]  dig;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .seg        (seg),
        .dig        (dig),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
    } slot_t;

    slot_t sb[$];
    int    tests    = 0;
    int    fails    = 0;
    int    fd_count = 0;
    int    cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (frame_done === 1'b1) fd_count <= fd_count + 1;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int i);
        logic [3:0] nib;
        nib = v[i*4 +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        begin
            int top;
            top = 0;
            for (int k = 0; k < 4; k++) if (v[k*4 +: 4] != 4'd0) top = k;
            if (i > top) return 7'b0000000;
        end
`endif
        return ref_seg(nib);
    endfunction

    task automatic push_slot(input logic [15:0] v, input int i);
        slot_t s;
        s.dig = 4'(1 << i);
        s.seg = exp_seg(v, i);
        sb.push_back(s);
    endtask

    task automatic push_frame(input logic [15:0] v);
        for (int i = 0; i < 4; i++) push_slot(v, i);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge where a new digit slot first appears; returns at
    // the negedge where the following slot (or blanking) first appears.
    task automatic check_slot();
        slot_t e;
        int    n;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 16'(sb.size()), 16'd1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        chk("slot_dig", 16'(dig), 16'(e.dig));
        chk("slot_seg", 16'(seg), 16'(e.seg));
        n = 0;
        do begin
            n++;
            @(negedge clk);
            load_valid = 1'b0;
        end while (dig === e.dig && n < 20);
        chk("slot_len", 16'(n), 16'd4);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int fd0;
        int n;

        rst_n      = 1'b0;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_seg", 16'(seg), 16'h0);
        chk("rst_dig", 16'(dig), 16'h0);
        chk("rst_frame_done", 16'(frame_done), 16'h0);
        chk("rst_load_ready", 16'(load_ready), 16'h1);

        // Release, enable and offer 0x1234 together.
        rst_n      = 1'b1;
        enable     = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'h1234;
        @(negedge clk);
        chk("first_dig", 16'(dig), 16'h1);
        chk("first_seg", 16'(seg), 16'h7E);
        chk("load_taken", 16'(load_ready), 16'h0);
        fd0 = fd_count;
        push_frame(16'h0000);
        push_frame(16'h1234);
        repeat (8) check_slot();
        chk("frame_done_2frames", 16'(fd_count - fd0), 16'd2);

        // Mid-frame load, then a second offer while the buffer is full.
        push_slot(16'h1234, 0);
        check_slot();
        load_valid = 1'b1;
        load_data  = 16'h5678;
        @(negedge clk);
        chk("pend_full_ready", 16'(load_ready), 16'h0);
        load_data = 16'h9999;
        @(negedge clk);
        chk("drop_ready", 16'(load_ready), 16'h0);
        load_valid = 1'b0;
        n = 0;
        while (dig === 4'b0010 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("resync_dig", 16'(dig), 16'h4);
        push_slot(16'h1234, 2);
        push_slot(16'h1234, 3);
        push_frame(16'h5678);
        push_frame(16'hA3B2);
        check_slot();
        chk("ready_before_commit", 16'(load_ready), 16'h0);
        check_slot();
        chk("ready_after_commit", 16'(load_ready), 16'h1);

        // Frame of 0x5678 with 0xA3B2 loaded at its start.
        load_valid = 1'b1;
        load_data  = 16'hA3B2;
        c0  = cyc;
        fd0 = fd_count;
        repeat (8) check_slot();
        chk("frame_cycles", 16'(cyc - c0), 16'd32);
        chk("frame_done_count", 16'(fd_count - fd0), 16'd2);

        // Pause during digit 2.
        push_slot(16'hA3B2, 0);
        push_slot(16'hA3B2, 1);
        check_slot();
        check_slot();
        enable = 1'b0;
        fd0    = fd_count;
        @(negedge clk);
        chk("dis_dig", 16'(dig), 16'h0);
        chk("dis_seg", 16'(seg), 16'h0);
        repeat (9) @(negedge clk);
        chk("dis_dig_end", 16'(dig), 16'h0);
        chk("dis_no_frame_done", 16'(fd_count - fd0), 16'd0);
        enable = 1'b1;
        n = 0;
        while (dig === 4'b0000 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("reenable_latency", 16'(n), 16'd1);
        push_slot(16'hA3B2, 2);
        push_slot(16'hA3B2, 3);
        check_slot();
        check_slot();

        // Reset mid-frame with a full pending buffer.
        load_valid = 1'b1;
        load_data  = 16'h4321;
        push_slot(16'hA3B2, 0);
        check_slot();
        chk("pend_before_rst", 16'(load_ready), 16'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seg", 16'(seg), 16'h0);
        chk("arst_dig", 16'(dig), 16'h0);
        chk("arst_frame_done", 16'(frame_done), 16'h0);
        chk("arst_load_ready", 16'(load_ready), 16'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_frame(16'h0000);
        push_frame(16'h0000);
        repeat (8) check_slot();
        chk("post_rst_ready", 16'(load_ready), 16'h1);
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
